// File: rtl/dmem_pkg.sv
// dmem_pkg: shared access-type encodings, FSM states and wait-counter width for the data memory unit
package dmem_pkg;
  localparam int LAT_W = 4;
  localparam logic [2:0] TY_WORD  = 3'b000;
  localparam logic [2:0] TY_HALF  = 3'b001;
  localparam logic [2:0] TY_HALFU = 3'b010;
  localparam logic [2:0] TY_BYTE  = 3'b011;
  localparam logic [2:0] TY_BYTEU = 3'b100;
  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;
  function automatic logic is_fault(input logic [2:0] ty, input logic [1:0] lo);
    return (ty > TY_BYTEU) || ((ty == TY_HALF || ty == TY_HALFU) && lo[0]) || (ty == TY_WORD && lo != 2'b00);
  endfunction
  function automatic logic [3:0] byte_en(input logic [2:0] ty, input logic [1:0] lo);
    return ty == TY_WORD ? 4'b1111 : (ty == TY_HALF || ty == TY_HALFU) ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b0001 << lo;
  endfunction
endpackage

// File: rtl/dmem_bank.sv
// dmem_bank: word-organised storage with byte-enabled write port and registered read port, no reset
module dmem_bank #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dmem_unit.sv
// dmem_unit: request/response data memory front end with fault checking, wait states and load extension
module dmem_unit
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_type,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);
  state_t state, state_nx;
  logic live, we_q, err_q, accept, fault, access;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] wdata_q, wrep, rd, lane, ext;
  logic [2:0] type_q;
  logic [LAT_W-1:0] cnt;
  assign req_ready = live && state == ST_IDLE;
  assign accept = req_valid && req_ready;
  assign fault = is_fault(req_type, req_addr[1:0]);
  assign access = state == ST_BUSY && cnt == '0;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= ST_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == ST_IDLE ? (accept ? (fault ? ST_RESP : ST_BUSY) : ST_IDLE) :
               state == ST_BUSY ? (cnt == '0 ? ST_RESP : ST_BUSY) :
               (resp_ready ? ST_IDLE : ST_RESP);
  end
  // live holds req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      live    <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      type_q  <= '0;
      cnt     <= '0;
    end else begin
      live <= 1'b1;
      if (accept) begin
        we_q    <= req_we;
        err_q   <= fault;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        type_q  <= req_type;
        cnt     <= LAT_W'(LATENCY);
      end else if (state == ST_BUSY && cnt != '0) cnt <= cnt - 1'b1;
    end
  assign wrep = type_q == TY_WORD ? wdata_q :
                (type_q == TY_HALF || type_q == TY_HALFU) ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  dmem_bank #(.AW(ADDR_W-2)) u_bank (
    .clk   (clk),
    .we    (access && we_q),
    .be    (byte_en(type_q, addr_q[1:0])),
    .waddr (addr_q[ADDR_W-1:2]),
    .wdata (wrep),
    .re    (access && !we_q),
    .raddr (addr_q[ADDR_W-1:2]),
    .rdata (rd)
  );
  assign lane = rd >> {addr_q[1:0], 3'b000};
  assign ext = type_q == TY_HALF  ? {{16{lane[15]}}, lane[15:0]} :
               type_q == TY_HALFU ? {16'h0, lane[15:0]} :
               type_q == TY_BYTE  ? {{24{lane[7]}}, lane[7:0]} :
               type_q == TY_BYTEU ? {24'h0, lane[7:0]} : rd;
  assign resp_valid = state == ST_RESP;
  assign resp_err = resp_valid && err_q;
  assign resp_rdata = resp_valid && !err_q && !we_q ? ext : '0;
endmodule

// File: tb/tb_dmem_unit.sv
// tb_dmem_unit: directed vector table plus reset and wait-state sequences for dmem_unit
module tb_dmem_unit;
  logic clk = 1'b0, rstn = 1'b0, sel = 1'b0;
  logic req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0] req_type = '0;
  logic rdy0, rdy3, rv0, rv3, err0, err3;
  logic [31:0] rd0, rd3;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  dmem_unit #(.ADDR_W(12), .LATENCY(0)) u0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid && !sel), .req_ready(rdy0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type), .resp_valid(rv0),
    .resp_ready(resp_ready), .resp_rdata(rd0), .resp_err(err0));
  dmem_unit #(.ADDR_W(12), .LATENCY(3)) u3 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid && sel), .req_ready(rdy3), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type), .resp_valid(rv3),
    .resp_ready(resp_ready), .resp_rdata(rd3), .resp_err(err3));
  assign req_ready  = sel ? rdy3 : rdy0;
  assign resp_valid = sel ? rv3 : rv0;
  assign resp_err   = sel ? err3 : err0;
  assign resp_rdata = sel ? rd3 : rd0;
  typedef struct {
    logic        we;
    logic [11:0] a;
    logic [31:0] wd;
    logic [2:0]  ty;
    logic [31:0] rd;
    logic        e;
    int          lat;
  } vec_t;
  localparam int NV = 24;
  vec_t v [NV];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic s, input logic we, input logic [11:0] a, input logic [31:0] wd,
                      input logic [2:0] ty, input int hold, input logic [31:0] exp_rd,
                      input logic exp_e, input int exp_lat, input string nm);
    int n;
    logic [31:0] rd;
    logic e;
    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_type = ty;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid && n < 40);
    rd = resp_rdata;
    e = resp_err;
    chk({nm, " latency"}, 32'(n), 32'(exp_lat));
    chk({nm, " rdata"}, rd, exp_rd);
    chk({nm, " err"}, {31'b0, e}, {31'b0, exp_e});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, " held rdata"}, resp_rdata, rd);
      chk({nm, " held valid/ready/err"}, {29'b0, resp_valid, req_ready, resp_err}, {29'b0, 1'b1, 1'b0, e});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 chk({nm, " after handshake valid/ready"}, {30'b0, resp_valid, req_ready}, 32'd1);
  endtask
  initial begin
    v[0]  = '{1'b1, 12'h010, 32'h89ABCDEF, 3'b000, 32'h0, 1'b0, 2};
    v[1]  = '{1'b0, 12'h010, 32'h0,        3'b000, 32'h89ABCDEF, 1'b0, 2};
    v[2]  = '{1'b0, 12'h013, 32'h0,        3'b011, 32'hFFFFFF89, 1'b0, 2};
    v[3]  = '{1'b0, 12'h013, 32'h0,        3'b100, 32'h00000089, 1'b0, 2};
    v[4]  = '{1'b0, 12'h012, 32'h0,        3'b001, 32'hFFFF89AB, 1'b0, 2};
    v[5]  = '{1'b0, 12'h010, 32'h0,        3'b010, 32'h0000CDEF, 1'b0, 2};
    v[6]  = '{1'b1, 12'h011, 32'hDEADBE55, 3'b011, 32'h0, 1'b0, 2};
    v[7]  = '{1'b0, 12'h010, 32'h0,        3'b000, 32'h89AB55EF, 1'b0, 2};
    v[8]  = '{1'b0, 12'h011, 32'h0,        3'b001, 32'h0, 1'b1, 1};
    v[9]  = '{1'b0, 12'h012, 32'h0,        3'b000, 32'h0, 1'b1, 1};
    v[10] = '{1'b0, 12'h010, 32'h0,        3'b111, 32'h0, 1'b1, 1};
    v[11] = '{1'b1, 12'h011, 32'h0000FFFF, 3'b010, 32'h0, 1'b1, 1};
    v[12] = '{1'b1, 12'h012, 32'h00000000, 3'b000, 32'h0, 1'b1, 1};
    v[13] = '{1'b1, 12'h010, 32'h00000000, 3'b101, 32'h0, 1'b1, 1};
    v[14] = '{1'b0, 12'h010, 32'h0,        3'b000, 32'h89AB55EF, 1'b0, 2};
    v[15] = '{1'b1, 12'h012, 32'hCAFE1234, 3'b001, 32'h0, 1'b0, 2};
    v[16] = '{1'b0, 12'h010, 32'h0,        3'b000, 32'h123455EF, 1'b0, 2};
    v[17] = '{1'b0, 12'h012, 32'h0,        3'b010, 32'h00001234, 1'b0, 2};
    v[18] = '{1'b0, 12'h010, 32'h0,        3'b011, 32'hFFFFFFEF, 1'b0, 2};
    v[19] = '{1'b1, 12'hFFC, 32'hA5A55A5A, 3'b000, 32'h0, 1'b0, 2};
    v[20] = '{1'b0, 12'hFFF, 32'h0,        3'b011, 32'hFFFFFFA5, 1'b0, 2};
    v[21] = '{1'b0, 12'hFFE, 32'h0,        3'b010, 32'h0000A5A5, 1'b0, 2};
    v[22] = '{1'b0, 12'hFFC, 32'h0,        3'b001, 32'h00005A5A, 1'b0, 2};
    v[23] = '{1'b1, 12'h020, 32'h11111111, 3'b000, 32'h0, 1'b0, 2};
    repeat (2) @(negedge clk);
    chk("reset ready/valid/err", {29'b0, rdy0, rv0, err0}, 32'd0);
    chk("reset rdata", rd0, 32'h0);
    chk("reset lat3 ready/valid", {30'b0, rdy3, rv3}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("ready after reset release", {31'b0, rdy0}, 32'd1);
    for (int i = 0; i < NV; i++)
      xfer(1'b0, v[i].we, v[i].a, v[i].wd, v[i].ty, 0, v[i].rd, v[i].e, v[i].lat, $sformatf("vec%0d", i));
    // reset during BUSY of a store must cancel the write
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020; req_wdata = 32'h22222222;
    req_type = 3'b000; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rstn = 1'b0;
    #1 chk("busy reset ready/valid/err", {29'b0, rdy0, rv0, err0}, 32'd0);
    chk("busy reset rdata", rd0, 32'h0);
    repeat (2) @(negedge clk);
    chk("busy reset held ready/valid", {30'b0, rdy0, rv0}, 32'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1 chk("ready after second reset", {31'b0, rdy0}, 32'd1);
    xfer(1'b0, 1'b0, 12'h020, 32'h0, 3'b000, 0, 32'h11111111, 1'b0, 2, "store cancelled");
    xfer(1'b1, 1'b1, 12'h040, 32'hCAFEF00D, 3'b000, 0, 32'h0, 1'b0, 5, "lat3 store");
    xfer(1'b1, 1'b0, 12'h040, 32'h0, 3'b000, 4, 32'hCAFEF00D, 1'b0, 5, "lat3 load held");
    xfer(1'b1, 1'b0, 12'h041, 32'h0, 3'b100, 0, 32'h000000F0, 1'b0, 5, "lat3 byteu");
    xfer(1'b1, 1'b0, 12'h043, 32'h0, 3'b010, 2, 32'h0, 1'b1, 1, "lat3 fault held");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dmem_unit.md
DMEM_UNIT -- requirements
Module: dmem_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, byte-address width; capacity 2**ADDR_W bytes.
REQ-002 SHALL have parameter LATENCY, default 0, extra wait cycles per legal access (0..15).
REQ-003 SHALL have one clock; reset is asynchronous and active-low; ports named clk and rstn.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rstn  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit can accept a request.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_W  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 req_type  input  3  000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer accepts response.
REQ-014 resp_rdata  output  32  load result, extended; 0 for stores and faults.
REQ-015 resp_err  output  1  access faulted.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge with req_valid & req_ready, latching we, addr, wdata, type.
REQ-018 Fault on accept: type 101/110/111, half/half-unsigned with addr[0]=1, or word with addr[1:0]!=0.
REQ-019 Faulted request SHALL go IDLE->RESP, resp_err=1, resp_rdata=0, no memory write.
REQ-020 Legal request SHALL go IDLE->BUSY, wait counter loaded with LATENCY.
REQ-021 In BUSY, counter != 0: decrement, stay BUSY.
REQ-022 In BUSY, counter == 0: perform the access on that edge, go to RESP.
REQ-023 resp_valid SHALL first assert 2+LATENCY cycles after the accept edge for legal requests, 1 cycle for faults.
REQ-024 In RESP: resp_valid=1, resp_rdata/resp_err held stable until resp_valid & resp_ready; then IDLE.
REQ-025 A request SHALL NOT be accepted in the cycle RESP completes; next accept is possible one cycle later, in IDLE.
REQ-026 Memory organised as 2**(ADDR_W-2) 32-bit words; word index addr[ADDR_W-1:2], byte lane addr[1:0].
REQ-027 Stores use byte enables: word 1111; half 0011 (addr[1]=0) or 1100 (addr[1]=1); byte one-hot on addr[1:0]; wdata replicated onto the lanes.
REQ-028 Loads: half sign-extends bit 15, half-unsigned zero-extends; byte sign-extends bit 7, byte-unsigned zero-extends; word unmodified; all little-endian.
REQ-029 Store completion SHALL return resp_valid with resp_err=0, resp_rdata=0.
REQ-030 Load after store to the same address SHALL return the new data (the store completes before the next accept).
REQ-031 Top-of-memory addresses SHALL NOT wrap; alignment rules make any access stay within one word.

Reset
REQ-032 On rstn low: state IDLE, counter 0, req_ready 0 while asserted, resp_valid 0, resp_err 0, resp_rdata 0.
REQ-033 req_ready SHALL rise the first cycle after rstn deasserts.
REQ-034 Memory contents SHALL NOT be reset; they are undefined until written.
REQ-035 Reset in BUSY before the access edge SHALL cancel the store (no write); reset in RESP SHALL drop the response.

Structure
REQ-036 Shared package SHALL hold the req_type encodings, FSM state encodings, and the LATENCY width constant.
REQ-037 Storage SHALL be sub-module dmem_bank: one write port with 4-bit byte enables, one registered read port, no reset.
REQ-038 dmem_unit SHALL contain the FSM, fault check, lane steering and extension logic.

Verification
REQ-039 LATENCY=0: store word 0x89ABCDEF to 0x010, then load word 0x010 -> resp_rdata 0x89ABCDEF, resp_err 0, resp_valid 2 cycles after each accept.
REQ-040 Load byte 0x013 -> 0xFFFFFF89; byte-unsigned 0x013 -> 0x00000089; half 0x012 -> 0xFFFF89AB; half-unsigned 0x010 -> 0x0000CDEF.
REQ-041 Store byte 0x55 to 0x011 over 0x89ABCDEF, then load word 0x010 -> 0x89AB55EF.
REQ-042 Load half 0x011, load word 0x012, and type 111 -> each resp_err 1, rdata 0, resp_valid 1 cycle after accept; memory unchanged.
REQ-043 LATENCY=3 with resp_ready low 4 cycles -> resp_valid at accept+5, rdata stable while held, req_ready 0 until the cycle after the handshake.
REQ-044 Assert rstn low during BUSY of a store to 0x020 (previously 0x11111111) -> outputs cleared, later load of 0x020 returns 0x11111111.
